// File: rtl/maxpool_pkg.sv
// Shared types and constants for the FP16 max-pool sequencer.
// Build option: define MAXPOOL_RELU_EN to fuse a ReLU into the result register.
package maxpool_pkg;

  localparam int          FP16_W        = 16;
  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/maxpool_seq_if.sv
// Stream interface for maxpool_seq: activation input stream and pooled output stream.
// slave = pooling block side, master = producer/consumer side.
interface maxpool_seq_if;
  import maxpool_pkg::*;

  logic              in_valid;
  logic [FP16_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [FP16_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/comparator.sv
// FP16 comparator: bigger_one is the numerically larger of floatA/floatB.
// Ties (including +0 vs -0) return floatB, so a stored maximum is kept on equality.
module comparator (
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic [15:0] bigger_one
);

  // Maps sign-magnitude FP16 onto an unsigned key with the same ordering.
  function automatic logic [15:0] order_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  logic w_both_zero;
  logic w_a_bigger;

  // Select the larger operand; zero magnitudes of either sign compare equal.
  always_comb begin
    w_both_zero = (floatA[14:0] == 15'd0) && (floatB[14:0] == 15'd0);
    w_a_bigger  = !w_both_zero && (order_key(floatA) > order_key(floatB));
    bigger_one  = w_a_bigger ? floatA : floatB;
  end

endmodule

// File: rtl/maxpool_seq.sv
// FP16 max-pool sequencer: emits the maximum of every WINDOW accepted inputs
// through one shared comparator. Build option MAXPOOL_RELU_EN clamps negative
// results to +0 as they are loaded into the output register.
module maxpool_seq
  import maxpool_pkg::*;
#(
  parameter int WINDOW = 4,
  parameter int CNT_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  maxpool_seq_if.slave  bus,
  output logic          busy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [FP16_W-1:0] r_max;
  logic [FP16_W-1:0] w_max_nxt;
  logic              r_out_valid;
  logic [FP16_W-1:0] r_out_data;
  logic              r_busy;

  logic              w_in_ready;
  logic              w_acc;
  logic              w_last;
  logic              w_done;
  logic [FP16_W-1:0] w_cmp_out;
  logic [FP16_W-1:0] w_out_load;

  // New element against the stored running maximum.
  comparator u_cmp (
    .floatA     (bus.in_data),
    .floatB     (r_max),
    .bigger_one (w_cmp_out)
  );

  // Input may advance whenever the output slot is empty or being drained.
  always_comb begin
    w_in_ready = !r_out_valid || bus.out_ready;
    w_acc      = bus.in_valid && w_in_ready;
    // Compare against WINDOW-1 so cnt never has to hold WINDOW itself.
    w_last     = (r_cnt == CNT_W'(WINDOW - 1));
  end

  // Value loaded into out_data when a window completes.
`ifdef MAXPOOL_RELU_EN
  always_comb w_out_load = w_cmp_out[15] ? FP16_POS_ZERO : w_cmp_out;
`else
  always_comb w_out_load = w_cmp_out;
`endif

  // Next-state logic for the window FSM, counter and running maximum.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_max_nxt   = r_max;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_max_nxt   = bus.in_data;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_acc) begin
          w_max_nxt = w_cmp_out;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter, running maximum and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_max   <= FP16_POS_ZERO;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_max   <= w_max_nxt;
      r_busy  <= (w_cnt_nxt != '0);
    end
  end

  // Output slot: a completing window overwrites; otherwise a handoff empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= FP16_POS_ZERO;
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out_load;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;

endmodule

// File: tb/tb_maxpool_seq.sv
// Self-checking bench for maxpool_seq: directed scenarios followed by random
// traffic, all compared against a numeric reference model of window maxima.
module tb_maxpool_seq;

  localparam int WINDOW = 4;

  logic clk;
  logic rst_n;
  logic busy;

  maxpool_seq_if bus ();

  maxpool_seq #(.WINDOW(WINDOW), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  string       phase  = "reset";

  // Reference model: accepted elements of the open window, and the output slot.
  logic [15:0] win[$];
  logic        m_valid;
  logic [15:0] m_data;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  // Numeric value of a finite FP16 pattern.
  function automatic real fp16_val(input logic [15:0] x);
    int  e;
    real mag;
    real scale;
    e     = int'(x[14:10]);
    scale = 1.0;
    if (e == 0) begin
      mag = real'(x[9:0]);
      e   = 1;
    end else begin
      mag = real'(x[9:0]) + 1024.0;
    end
    for (int i = 0; i < 25 - e; i++) scale = scale / 2.0;
    for (int i = 0; i < e - 25; i++) scale = scale * 2.0;
    mag = mag * scale;
    return x[15] ? -mag : mag;
  endfunction

  // Largest element of the window; an equal later element does not replace the earlier one.
  function automatic logic [15:0] window_max();
    logic [15:0] m;
    m = win[0];
    for (int i = 1; i < win.size(); i++)
      if (fp16_val(win[i]) > fp16_val(m)) m = win[i];
    return m;
  endfunction

  function automatic logic [15:0] relu(input logic [15:0] m);
`ifdef MAXPOOL_RELU_EN
    return m[15] ? 16'h0000 : m;
`else
    return m;
`endif
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] pool [5];
    pool = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000, 16'h4000};
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom)};
  endfunction

  // One clock: drive inputs at the falling edge, check in_ready, advance the
  // model by one edge, then check the registered outputs at the next falling edge.
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    logic        exp_rdy;
    logic        done;
    logic [15:0] res;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    exp_rdy = !m_valid || r;
    check("in_ready", {15'd0, bus.in_ready}, {15'd0, exp_rdy});
    done = 1'b0;
    res  = 16'h0000;
    if (v && exp_rdy) begin
      win.push_back(d);
      if (win.size() == WINDOW) begin
        res  = window_max();
        done = 1'b1;
        win.delete();
      end
    end
    if (done) begin
      m_valid = 1'b1;
      m_data  = relu(res);
    end else if (r) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
    check("out_data", bus.out_data, m_data);
    check("busy", {15'd0, busy}, {15'd0, (win.size() != 0)});
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_out_data", bus.out_data, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
  endtask

  initial begin
    logic [15:0] t4 [8];
    logic        v;
    logic        r;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    m_valid       = 1'b0;
    m_data        = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic max, result visible for exactly one cycle.
    phase = "basic";
    step(1'b1, 16'h3C00, 1'b1);
    step(1'b1, 16'h4000, 1'b1);
    step(1'b1, 16'hBC00, 1'b1);
    step(1'b1, 16'h3800, 1'b1);
    check("const_valid", {15'd0, bus.out_valid}, 16'd1);
    check("const_max", bus.out_data, 16'h4000);
    step(1'b0, 16'h0000, 1'b1);
    check("const_one_cycle", {15'd0, bus.out_valid}, 16'd0);

    // All-negative window.
    phase = "negative";
    step(1'b1, 16'hBC00, 1'b1);
    step(1'b1, 16'hC000, 1'b1);
    step(1'b1, 16'hBC00, 1'b1);
    step(1'b1, 16'hC000, 1'b1);
`ifdef MAXPOOL_RELU_EN
    check("const_max", bus.out_data, 16'h0000);
`else
    check("const_max", bus.out_data, 16'hBC00);
`endif
    step(1'b0, 16'h0000, 1'b1);

    // Backpressure: result held, input stalled, nothing lost afterwards.
    phase = "backpressure";
    step(1'b1, 16'h3C00, 1'b0);
    step(1'b1, 16'h4000, 1'b0);
    step(1'b1, 16'hBC00, 1'b0);
    step(1'b1, 16'h3800, 1'b0);
    repeat (5) step(1'b1, 16'h3800, 1'b0);
    check("const_held", bus.out_data, 16'h4000);
    step(1'b1, 16'h3800, 1'b1);
    check("const_new_window", {15'd0, busy}, 16'd1);
    step(1'b1, 16'h3000, 1'b1);
    step(1'b1, 16'h3400, 1'b1);
    step(1'b1, 16'h3C00, 1'b1);
    check("const_max", bus.out_data, 16'h3C00);
    step(1'b0, 16'h0000, 1'b1);

    // Back-to-back windows with no bubble.
    phase = "back2back";
    t4 = '{16'h3C00, 16'h4000, 16'h3800, 16'h3C00, 16'hC000, 16'hBC00, 16'h3800, 16'hBC00};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t4[i], 1'b1);
      if (i == 3) check("const_first", bus.out_data, 16'h4000);
    end
    check("const_second", bus.out_data, 16'h3800);
    step(1'b0, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of a window.
    phase = "midreset";
    step(1'b1, 16'h4400, 1'b1);
    step(1'b1, 16'h4000, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    win.delete();
    m_valid = 1'b0;
    m_data  = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h3C00, 1'b1);
    step(1'b1, 16'h3800, 1'b1);
    step(1'b1, 16'h3400, 1'b1);
    step(1'b1, 16'h3000, 1'b1);
    check("const_max", bus.out_data, 16'h3C00);
    step(1'b0, 16'h0000, 1'b1);

    // Gapped input stream.
    phase = "gapped";
    step(1'b1, 16'h3000, 1'b1);
    step(1'b0, 16'h7BFF, 1'b1);
    step(1'b1, 16'h3800, 1'b1);
    step(1'b0, 16'h7BFF, 1'b1);
    step(1'b1, 16'h3400, 1'b1);
    check("const_busy", {15'd0, busy}, 16'd1);
    step(1'b0, 16'h7BFF, 1'b1);
    step(1'b1, 16'h3C00, 1'b1);
    check("const_max", bus.out_data, 16'h3C00);
    check("const_idle", {15'd0, busy}, 16'd0);

    // Random traffic with random backpressure.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 9) < 7);
      step(v, rand_fp16(), r);
    end
    repeat (3) step(1'b0, 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
